// File: rtl/aoi_chk_pkg.sv
// rtl/aoi_chk_pkg.sv - shared types, constants and reference model for the AOI response checker
package aoi_chk_pkg;

   localparam int          VEC_W   = 4;
   localparam int          RESP_W  = 3;
   localparam logic [15:0] ALL_COV = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Stimulus is {a,b,c,d}; response is {e,f,g}.
   function automatic logic [RESP_W-1:0] aoi_expect(input logic [VEC_W-1:0] vec);
      logic e_l;
      logic f_l;
      e_l = vec[3] & vec[2];
      f_l = vec[1] & vec[0];
      return {e_l, f_l, ~(e_l | f_l)};
   endfunction

endpackage

// File: rtl/aoi_delay_line.sv
// rtl/aoi_delay_line.sv - DEPTH-deep stimulus delay line with a fill-valid bit per stage
module aoi_delay_line
   import aoi_chk_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             in_valid_i,
   input  logic [VEC_W-1:0] in_vec_i,
   output logic [VEC_W-1:0] out_vec_o,
   output logic             out_valid_o
);

   logic [VEC_W-1:0] vec_q [DEPTH];
   logic [DEPTH-1:0] vld_q;

   // A clear flushes the older stages while the head still takes the new run's first sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) vec_q[i] <= '0;
         vld_q <= '0;
      end else begin
         vec_q[0] <= in_vec_i;
         vld_q[0] <= in_valid_i;
         for (int i = 1; i < DEPTH; i++) begin
            vec_q[i] <= clr_i ? '0   : vec_q[i-1];
            vld_q[i] <= clr_i ? 1'b0 : vld_q[i-1];
         end
      end
   end

   assign out_vec_o   = vec_q[DEPTH-1];
   assign out_valid_o = vld_q[DEPTH-1];

endmodule

// File: rtl/aoi_response_checker.sv
// rtl/aoi_response_checker.sv - checks AOI gate responses against the reference model,
// tracking mismatches, input coverage and the first failing vector
module aoi_response_checker
   import aoi_chk_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             e,
   input  logic             f,
   input  logic             g,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [15:0]      cov,
   output logic             ff_valid,
   output logic [6:0]       ff_vec
);

   state_e              state_q, state_d;
   logic                clr, in_valid, dl_valid, chk_d, chk_q, mism, cov_full;
   logic [VEC_W-1:0]    dl_vec, stim_q;
   logic [RESP_W-1:0]   resp_q;
   logic [CNT_W-1:0]    err_q, err_d;
   logic [15:0]         cov_q, cov_d;
   logic                ffv_q, ffv_d;
   logic [6:0]          ffvec_q, ffvec_d;
   logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;

   assign cov_full = (cov_q == ALL_COV);
   assign clr      = start && ((state_q == IDLE) || (state_q == DONE));
   assign in_valid = (state_d == ARM) || (state_d == RUN);

   aoi_delay_line #(.DEPTH(SETTLE)) u_delay (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr),
      .in_valid_i  (in_valid),
      .in_vec_i    ({a, b, c, d}),
      .out_vec_o   (dl_vec),
      .out_valid_o (dl_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ARM;
         ARM:     if (stop) state_d = DONE; else if (dl_valid) state_d = RUN;
         RUN:     if (stop || cov_full) state_d = DONE;
         DONE:    if (start) state_d = ARM;
         default: state_d = IDLE;
      endcase
   end

   // Response captured now is paired with the stimulus leaving the delay line; judged next cycle.
   assign chk_d = dl_valid && ((state_q == ARM) || (state_q == RUN)) && !cov_full;
   assign mism  = (resp_q != aoi_expect(stim_q));

   always_comb begin
      err_d   = err_q;
      cov_d   = cov_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
      if (clr) begin
         err_d   = '0;
         cov_d   = '0;
         ffv_d   = 1'b0;
         ffvec_d = '0;
      end else if (chk_q) begin
         cov_d = cov_q | (16'd1 << stim_q);
         if (mism) begin
            if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
            if (!ffv_q) begin
               ffv_d   = 1'b1;
               ffvec_d = {stim_q, resp_q};
            end
         end
      end
   end

   // done waits for a check captured on the stop edge to land, so pass is final when done rises.
   assign done_d = (state_d == DONE) && !chk_d;
   assign busy_d = (state_d != IDLE) && !done_d;
   assign pass_d = done_d && (err_d == '0) && (cov_d == ALL_COV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stim_q  <= '0;
         resp_q  <= '0;
         chk_q   <= 1'b0;
         err_q   <= '0;
         cov_q   <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stim_q  <= dl_vec;
         resp_q  <= {e, f, g};
         chk_q   <= chk_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign cov      = cov_q;
   assign ff_valid = ffv_q;
   assign ff_vec   = ffvec_q;

endmodule

// File: doc/aoi_response_checker.md
# aoi_response_checker

Synthesizable response checker for the four-input AOI gate family: it is the receiving end of the stimulus path. It samples the gate inputs (a,b,c,d) and the gate outputs (e,f,g) every clock and compares the outputs against a reference model after a configurable settle delay. It counts mismatches, records input-combination coverage, captures the first failure and reports pass/fail once all 16 input combinations have been checked. It sits beside the gate under test in self-checking benches and on-board BIST wrappers.

## Interface
- SETTLE, 2: cycles between stimulus sample and response check; legal range 1..8.
- CNT_W, 16: width of the mismatch counter.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a new check run.
- stop  in  1  one-cycle pulse; ends a run early.
- a, b, c, d  in  1 each  gate inputs as driven to the DUT.
- e, f, g  in  1 each  DUT outputs.
- busy  out  1  high in ARM or RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 = zero mismatches and full coverage.
- err_cnt  out  CNT_W  mismatch count, saturating.
- cov  out  16  bit i set once input vector {a,b,c,d}==i has been checked.
- ff_valid  out  1  a first failure has been captured.
- ff_vec  out  7  {a,b,c,d,e,f,g} of the first failing check.

## Operation
- Reference model: e = a&b; f = c&d; g = ~(e|f).
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE: start -> ARM; err_cnt, cov, ff_valid, ff_vec cleared on the same edge.
- ARM: delay line fills for SETTLE cycles -> RUN. No checks are performed.
- RUN: every cycle, the response sampled at edge t is checked against the stimulus sampled at edge t-SETTLE.
- Mismatch: err_cnt increments, holding at all-ones. On the first mismatch, ff_vec is loaded and ff_valid is set.
- Every check sets cov[stimulus vector].
- RUN -> DONE when cov becomes 16'hFFFF, or on stop.
- pass = (err_cnt==0) && (cov==16'hFFFF).
- DONE: outputs hold. start -> ARM with clear.
- ARM: stop -> DONE with pass=0.
- Simultaneous start and stop: start wins in IDLE and DONE. stop wins in ARM and RUN.
- start in ARM or RUN is ignored.
- A check on the same edge as stop is still performed and counted.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, cov=0, ff_valid=0, ff_vec=0. FSM=IDLE. Delay line cleared.
- Reset mid-run aborts immediately. Nothing is retained.
- All outputs are registered.
- err_cnt, cov and ff_* reflect a check one cycle after the edge on which the response was sampled.
- done rises on the cycle after cov reaches 16'hFFFF, with pass valid on that same cycle.
- busy rises on the cycle after start.
- The first check occurs SETTLE cycles after entry to ARM.

## Structure
- Package aoi_chk_pkg holds:
  - state enum (IDLE, ARM, RUN, DONE);
  - function aoi_expect(4-bit) -> 3-bit {e,f,g};
  - constants VEC_W=4, RESP_W=3, ALL_COV=16'hFFFF.
- Sub-module aoi_delay_line: SETTLE-deep shift register carrying the 4-bit stimulus and a fill-valid bit. Cleared on reset and on start.
- Top level holds the FSM, counter, coverage and capture logic.

## Test plan
- Correct DUT, stimulus counting 0..15 once per cycle, SETTLE=2, then:
  - done is high 19 cycles after start;
  - pass=1, err_cnt=0, cov=16'hFFFF, ff_valid=0.
- Force g stuck-at-0 during stimulus 4'b0000 (expected 1) in that sweep:
  - err_cnt=1, pass=0;
  - ff_vec=7'b0000_000, ff_valid=1.
- Force e inverted on every check, with CNT_W=4 over 40 RUN cycles:
  - err_cnt saturates at 15 and does not wrap.
- stop after 5 distinct vectors:
  - done=1, pass=0, cov has exactly 5 bits set.
- start and stop asserted together in IDLE:
  - ARM is entered, busy=1.
  - The same pair in RUN goes to DONE.
- rst_n pulsed low mid-RUN with err_cnt=3:
  - all outputs zero asynchronously, FSM=IDLE.
  - A new start runs a clean sweep.
